// File: rtl/postnorm_seq.sv
// Sequential post-normalizer and round-to-nearest-even stage for the FP multiplier.
// Shifts the raw product into place one bit per cycle, then packs sign/exponent/fraction with flags.
module postnorm_seq #(
    parameter int WEXP    = 8,
    parameter int WSIG    = 23,
    parameter int WEXPSUM = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2*WSIG+1:0]      prod,
    input  logic [WEXPSUM-1:0]     expsum,
    input  logic                   sign,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WEXP+WSIG:0]     result,
    output logic                   underflow,
    output logic                   overflow,
    output logic                   inexact
);

    localparam int M  = 2*WSIG+1;
    localparam int WE = WEXPSUM+1;
    localparam logic signed [WE-1:0] ONE     = WE'(1);
    localparam logic signed [WE-1:0] EXP_MAX = WE'((1 << WEXP) - 1);

    typedef enum logic [2:0] {IDLE, NORM, DENORM, ROUND, DONE} state_t;

    state_t                 state, state_n;
    logic [M:0]             sig, sig_n;
    logic signed [WE-1:0]   exp, exp_n;
    logic                   sticky, sticky_n;
    logic                   s, s_n;
    logic [WEXP+WSIG:0]     result_n;
    logic                   underflow_n, overflow_n, inexact_n;

    logic [WSIG:0]          mant, mant_r;
    logic [WSIG+1:0]        mant_inc;
    logic                   guard, rs, round_up;
    logic signed [WE-1:0]   exp_r;
    logic [WEXP-1:0]        field;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sig       <= '0;
            exp       <= '0;
            sticky    <= 1'b0;
            s         <= 1'b0;
            result    <= '0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
            inexact   <= 1'b0;
        end else begin
            state     <= state_n;
            sig       <= sig_n;
            exp       <= exp_n;
            sticky    <= sticky_n;
            s         <= s_n;
            result    <= result_n;
            underflow <= underflow_n;
            overflow  <= overflow_n;
            inexact   <= inexact_n;
        end
    end

    // Rounding datapath; a carry out of the significand renormalizes to 1.0 with exp+1.
    always_comb begin
        mant     = sig[M:M-WSIG];
        guard    = sig[M-WSIG-1];
        rs       = (|sig[M-WSIG-2:0]) | sticky;
        round_up = guard & (rs | mant[0]);
        mant_inc = {1'b0, mant} + {{(WSIG+1){1'b0}}, round_up};
        if (mant_inc[WSIG+1]) begin
            mant_r = {1'b1, {WSIG{1'b0}}};
            exp_r  = exp + ONE;
        end else begin
            mant_r = mant_inc[WSIG:0];
            exp_r  = exp;
        end
        field = mant_r[WSIG] ? exp_r[WEXP-1:0] : '0;
    end

    always_comb begin
        state_n     = state;
        sig_n       = sig;
        exp_n       = exp;
        sticky_n    = sticky;
        s_n         = s;
        result_n    = result;
        underflow_n = underflow;
        overflow_n  = overflow;
        inexact_n   = inexact;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sig_n    = prod;
                    exp_n    = {expsum[WEXPSUM-1], expsum} + ONE;
                    sticky_n = 1'b0;
                    s_n      = sign;
                    if (prod == '0) begin
                        result_n    = {sign, {(WEXP+WSIG){1'b0}}};
                        underflow_n = 1'b0;
                        overflow_n  = 1'b0;
                        inexact_n   = 1'b0;
                        state_n     = DONE;
                    end else begin
                        state_n = NORM;
                    end
                end
            end
            NORM: begin
                if (!sig[M] && exp > ONE) begin
                    sig_n = {sig[M-1:0], 1'b0};
                    exp_n = exp - ONE;
                end else begin
                    state_n = DENORM;
                end
            end
            // Right shifts stop once the significand empties, bounding very negative exponents.
            DENORM: begin
                if (sig == '0) begin
                    state_n = ROUND;
                end else if (exp < ONE) begin
                    sticky_n = sticky | sig[0];
                    sig_n    = {1'b0, sig[M:1]};
                    exp_n    = exp + ONE;
                end else begin
                    state_n = ROUND;
                end
            end
            ROUND: begin
                if (mant_r[WSIG] && exp_r >= EXP_MAX) begin
                    result_n    = {s, {WEXP{1'b1}}, {WSIG{1'b0}}};
                    overflow_n  = 1'b1;
                    inexact_n   = 1'b1;
                    underflow_n = 1'b0;
                end else begin
                    result_n    = {s, field, mant_r[WSIG-1:0]};
                    overflow_n  = 1'b0;
                    inexact_n   = guard | rs;
                    underflow_n = (guard | rs) & (field == '0);
                end
                state_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_postnorm_seq.sv
// Directed self-checking bench for postnorm_seq: normal, denormal, rounding,
// overflow, zero product, backpressure and mid-operation reset.
module tb_postnorm_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [47:0] prod;
    logic [9:0]  expsum;
    logic        sign;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        underflow, overflow, inexact;

    int checks = 0;
    int errors = 0;

    postnorm_seq dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .prod(prod), .expsum(expsum), .sign(sign),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .underflow(underflow), .overflow(overflow), .inexact(inexact)
    );

    always #5 clk = ~clk;

    // Presents one operand and waits for out_valid; lat counts the accepting edge as 1.
    task automatic do_op(input logic [47:0] p, input logic [9:0] e, input logic sg,
                         output int lat, output logic timeout);
        @(negedge clk);
        prod = p; expsum = e; sign = sg; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        timeout = !out_valid;
    endtask

    task automatic finish_op();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++; $display("[TB] FAIL reset_handshake: got %b expected 10", {in_ready, out_valid});
        end
        checks++;
        if ({result, underflow, overflow, inexact} !== 35'd0) begin
            errors++; $display("[TB] FAIL reset_outputs: got %h expected 0", {result, underflow, overflow, inexact});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_normal();
        int lat; logic to;
        do_op(48'h900000000000, 10'd127, 1'b0, lat, to);
        checks++;
        if (to || result !== 32'h40100000 || {underflow, overflow, inexact} !== 3'b000) begin
            errors++; $display("[TB] FAIL mul_1p5: got %h flags %b expected 40100000 flags 000", result, {underflow, overflow, inexact});
        end
        checks++;
        if (lat !== 4) begin
            errors++; $display("[TB] FAIL lat_1p5: got %0d expected 4", lat);
        end
        finish_op();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL ready_after_done: got %b expected 1", in_ready);
        end
        do_op(48'h400000000000, 10'd127, 1'b0, lat, to);
        checks++;
        if (to || result !== 32'h3F800000 || {underflow, overflow, inexact} !== 3'b000) begin
            errors++; $display("[TB] FAIL mul_1p0: got %h flags %b expected 3f800000 flags 000", result, {underflow, overflow, inexact});
        end
        checks++;
        if (lat !== 5) begin
            errors++; $display("[TB] FAIL lat_1p0: got %0d expected 5", lat);
        end
        finish_op();
    endtask

    task automatic test_denormal();
        int lat; logic to;
        do_op(48'h400000000000, -10'sd2, 1'b0, lat, to);
        checks++;
        if (to || result !== 32'h00100000 || {underflow, overflow, inexact} !== 3'b000) begin
            errors++; $display("[TB] FAIL denorm_exact: got %h flags %b expected 00100000 flags 000", result, {underflow, overflow, inexact});
        end
        checks++;
        if (lat !== 6) begin
            errors++; $display("[TB] FAIL lat_denorm: got %0d expected 6", lat);
        end
        finish_op();
        do_op(48'h400000000000, -10'sd400, 1'b0, lat, to);
        checks++;
        if (to || result !== 32'h00000000 || {underflow, overflow, inexact} !== 3'b101) begin
            errors++; $display("[TB] FAIL denorm_flush: got %h flags %b expected 00000000 flags 101", result, {underflow, overflow, inexact});
        end
        checks++;
        if (lat !== 51) begin
            errors++; $display("[TB] FAIL lat_flush: got %0d expected 51", lat);
        end
        finish_op();
    endtask

    task automatic test_rounding();
        int lat; logic to;
        do_op(48'h800001800000, 10'd127, 1'b0, lat, to);
        checks++;
        if (to || result !== 32'h40000002 || {underflow, overflow, inexact} !== 3'b001) begin
            errors++; $display("[TB] FAIL rne_up: got %h flags %b expected 40000002 flags 001", result, {underflow, overflow, inexact});
        end
        finish_op();
        do_op(48'h800000800000, 10'd127, 1'b0, lat, to);
        checks++;
        if (to || result !== 32'h40000000 || {underflow, overflow, inexact} !== 3'b001) begin
            errors++; $display("[TB] FAIL rne_tie_even: got %h flags %b expected 40000000 flags 001", result, {underflow, overflow, inexact});
        end
        finish_op();
    endtask

    task automatic test_overflow();
        int lat; logic to;
        do_op(48'h800000000000, 10'd254, 1'b1, lat, to);
        checks++;
        if (to || result !== 32'hFF800000 || {underflow, overflow, inexact} !== 3'b011) begin
            errors++; $display("[TB] FAIL overflow: got %h flags %b expected ff800000 flags 011", result, {underflow, overflow, inexact});
        end
        finish_op();
    endtask

    task automatic test_zero();
        int lat; logic to;
        do_op(48'h0, 10'd100, 1'b0, lat, to);
        checks++;
        if (to || result !== 32'h00000000 || {underflow, overflow, inexact} !== 3'b000 || lat !== 1) begin
            errors++; $display("[TB] FAIL zero_prod: got %h flags %b lat %0d expected 00000000 flags 000 lat 1", result, {underflow, overflow, inexact}, lat);
        end
        finish_op();
    endtask

    task automatic test_backpressure();
        int lat; logic to; int bad;
        bad = 0;
        do_op(48'h900000000000, 10'd127, 1'b0, lat, to);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (to || !out_valid || in_ready || result !== 32'h40100000) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("[TB] FAIL hold_stable: got %0d bad cycles expected 0 (last result %h)", bad, result);
        end
        finish_op();
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++; $display("[TB] FAIL release: got %b expected 10", {in_ready, out_valid});
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        @(negedge clk);
        prod = 48'h000000000001; expsum = 10'd127; sign = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL busy_in_norm: got in_ready %b expected 0", in_ready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++; $display("[TB] FAIL async_reset: got %b expected 10", {in_ready, out_valid});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("[TB] FAIL no_result_after_reset: got %0d valid cycles expected 0", seen);
        end
    endtask

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        prod      = '0;
        expsum    = '0;
        sign      = 1'b0;
        test_reset();
        test_normal();
        test_denormal();
        test_rounding();
        test_overflow();
        test_zero();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/postnorm_seq.md
# postnorm_seq

Sequential post-normalizer and rounder for the floating-point multiplier datapath; it is the output-side counterpart of the input pre-normalization stage. Accepts the raw significand product, biased exponent sum (two's complement, may be negative or above range) and result sign. Normalizes by left shift, denormalizes by right shift with sticky collection, and rounds to nearest-even. Emits a packed IEEE-style result with underflow/overflow/inexact flags over a valid/ready handshake.

## Interface
- WEXP, 8, exponent field width
- WSIG, 23, stored fraction width (hidden bit excluded)
- WEXPSUM, 10, width of incoming two's complement exponent sum
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand bundle valid
- in_ready  output  1  block can accept; high only in IDLE
- prod  input  2*WSIG+2  unsigned significand product, binary point between bits 2*WSIG and 2*WSIG-1
- expsum  input  WEXPSUM  signed biased exponent of prod as interpreted above
- sign  input  1  result sign
- out_valid  output  1  result valid; high only in DONE
- out_ready  input  1  consumer accepts result
- result  output  WEXP+WSIG+1  {sign, exponent field, fraction}
- underflow, overflow, inexact  output  1 each  exception flags, valid with out_valid

## Operation
- Internal: sig (2*WSIG+2 bits, MSB index M=2*WSIG+1), exp signed WEXPSUM+1 bits (no wrap), sticky, s.
- IDLE: in_ready=1. On in_valid: latch sig=prod, exp=expsum+1 (point moves above bit M), sticky=0, s=sign. prod==0 -> DONE with result={s,0...0}, flags 0. Else -> NORM.
- NORM: if sig[M]==0 and exp>1: sig<<=1, exp-=1, stay. Else -> DENORM.
- DENORM: if sig==0 -> ROUND. Else if exp<1: sticky|=sig[0], sig>>=1, exp+=1, stay. Else -> ROUND. Bounds DENORM to at most 2*WSIG+3 shifts regardless of expsum.
- ROUND: mant=sig[M:M-WSIG], guard=sig[M-WSIG-1], rs=|sig[M-WSIG-2:0] | sticky. Increment mant iff guard & (rs | mant[0]). Carry out of mant -> mant=1.0, exp+=1. Field = (mant hidden bit==0) ? 0 : exp (denormal/zero when exp==1, hidden 0; a denormal rounding up into hidden=1 yields field 1). -> DONE.
- Overflow: final exp >= 2^WEXP-1 -> result={s, all ones, zero fraction}, overflow=1, inexact=1.
- inexact = guard | rs (or overflow). underflow = inexact & (field==0).
- DONE: out_valid=1; result/flags held stable until out_valid & out_ready, then -> IDLE.
- NaN/infinity/zero-operand special cases are resolved upstream; not handled here.

## Timing
- Reset: state IDLE, in_ready=1, out_valid=0, result=0, all flags 0. Reset mid-operation abandons the operand; no output is produced for it.
- Latency from accepting edge to first out_valid-high edge: 4 + L + R cycles (L = left shifts, R = right shifts); zero product: 1 cycle.
- in_ready=0 from the cycle after acceptance until the DONE handshake completes; no overlap, one operand in flight.
- in_ready rises the cycle after out_valid & out_ready; no combinational in->out paths.

## Test plan
- 1.5x1.5: prod=0x900000000000, expsum=127, sign=0 -> result 0x40100000, flags 0, out_valid 4 cycles after accept.
- 1.0x1.0: prod=0x400000000000, expsum=127 -> one left shift, 0x3F800000, latency 5.
- Denormal: prod=0x400000000000, expsum=-2 -> two right shifts, 0x00100000, underflow=0, inexact=0, latency 6; expsum=-400 -> result 0x00000000, underflow=1, inexact=1, DENORM exits on sig==0.
- RNE: prod=0x800001800000, expsum=127 -> 0x40000002, inexact=1; prod=0x800000800000 -> 0x40000000 (tie to even), inexact=1.
- Overflow: prod=0x800000000000, expsum=254, sign=1 -> 0xFF800000, overflow=1, inexact=1.
- Handshake/reset: hold out_ready=0 for 10 cycles -> result stable, in_ready=0; prod=0 -> 0x00000000 one cycle after accept; assert rst during NORM -> out_valid 0 and in_ready 1 immediately, no result afterwards.
